// File: rtl/intc_pkg.sv
// rtl/intc_pkg.sv - INTCON bit positions, FSM encoding and pending-interrupt helper
package intc_pkg;

  localparam int GIE_BIT  = 7;
  localparam int PEIE_BIT = 6;
  localparam int T0IE_BIT = 5;
  localparam int INTE_BIT = 4;
  localparam int RBIE_BIT = 3;
  localparam int T0IF_BIT = 2;
  localparam int INTF_BIT = 1;
  localparam int RBIF_BIT = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } intc_state_t;

  // periph_hit is the OR-reduced PIE1 & PIR1 vector, so this stays width-independent
  function automatic logic pend_calc(input logic [7:0] intcon, input logic periph_hit);
    return (intcon[T0IE_BIT] & intcon[T0IF_BIT]) |
           (intcon[INTE_BIT] & intcon[INTF_BIT]) |
           (intcon[RBIE_BIT] & intcon[RBIF_BIT]) |
           (intcon[PEIE_BIT] & periph_hit);
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// rtl/interrupt_controller_if.sv - SFR write bus and core interrupt handshake
interface interrupt_controller_if #(
  parameter int PIE_WIDTH = 8
);
  logic                 intcon_wr_en;
  logic                 pie1_wr_en;
  logic [7:0]           d;
  logic [7:0]           intcon_q;
  logic [PIE_WIDTH-1:0] pie1_q;
  logic                 irq_ack;
  logic                 retfie;
  logic                 irq_req;
  logic                 wake;

  // core side: issues SFR writes and vector/return events
  modport master (
    output intcon_wr_en, pie1_wr_en, d, irq_ack, retfie,
    input  intcon_q, pie1_q, irq_req, wake
  );

  // controller side
  modport slave (
    input  intcon_wr_en, pie1_wr_en, d, irq_ack, retfie,
    output intcon_q, pie1_q, irq_req, wake
  );
endinterface

// File: rtl/int_edge_detect.sv
// rtl/int_edge_detect.sv - synchronise RB0/INT pin and produce a selected-edge pulse
module int_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  input  logic intedg,
  output logic edge_pulse
);

  logic sync0;
  logic sync1;
  logic prev;

  // two-flop synchroniser for the asynchronous pin, plus one history stage
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync0 <= pin;
      sync1 <= sync0;
      prev  <= sync1;
    end
  end

  // intedg picks rising (1) or falling (0); a mid-stream intedg flip may give one extra pulse
  always_comb begin
    edge_pulse = intedg ? (sync1 & ~prev) : (~sync1 & prev);
  end

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - INTCON/PIE1 registers, pending logic and GIE request FSM
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int                   PIE_WIDTH    = 8,
  parameter logic [7:0]           INTCON_RESET = 8'h00,
  parameter logic [PIE_WIDTH-1:0] PIE1_RESET   = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  interrupt_controller_if.slave    bus,
  input  logic [PIE_WIDTH-1:0]     pir1_q,
  input  logic                     t0_ovf_strobe,
  input  logic                     rb_chg_strobe,
  input  logic                     int_pin,
  input  logic                     intedg
);

  intc_state_t          state;
  logic [7:0]           intcon_r;
  logic [PIE_WIDTH-1:0] pie1_r;
  logic                 irq_req_r;
  logic [7:0]           intcon_nxt;
  logic [PIE_WIDTH-1:0] pie1_nxt;
  logic                 int_edge;
  logic                 pend;
  logic                 pend_nxt;

  int_edge_detect u_edge (
    .clk        (clk),
    .rst        (rst),
    .pin        (int_pin),
    .intedg     (intedg),
    .edge_pulse (int_edge)
  );

  // next register values: SFR write, then source pulses win over flag clears, then GIE events
  always_comb begin
    intcon_nxt = intcon_r;
    pie1_nxt   = pie1_r;
    if (bus.intcon_wr_en) intcon_nxt = bus.d;
    if (bus.pie1_wr_en)   pie1_nxt   = bus.d[PIE_WIDTH-1:0];
    if (t0_ovf_strobe)    intcon_nxt[T0IF_BIT] = 1'b1;
    if (int_edge)         intcon_nxt[INTF_BIT] = 1'b1;
    if (rb_chg_strobe)    intcon_nxt[RBIF_BIT] = 1'b1;
    if (state == ST_REQ && bus.irq_ack)
      intcon_nxt[GIE_BIT] = 1'b0;
    else if (state == ST_SERVICE && bus.retfie)
      intcon_nxt[GIE_BIT] = 1'b1;
  end

  // pending now (drives wake and IDLE request) and as of next edge (drives REQ retraction)
  always_comb begin
    pend     = pend_calc(intcon_r, |(pie1_r & pir1_q));
    pend_nxt = pend_calc(intcon_nxt, |(pie1_nxt & pir1_q));
  end

  // SFR registers and request FSM with registered irq_req
  always_ff @(posedge clk) begin
    if (rst) begin
      intcon_r  <= INTCON_RESET;
      pie1_r    <= PIE1_RESET;
      irq_req_r <= 1'b0;
      state     <= ST_IDLE;
    end else begin
      intcon_r <= intcon_nxt;
      pie1_r   <= pie1_nxt;
      case (state)
        ST_IDLE: begin
          if (intcon_r[GIE_BIT] && pend) begin
            state     <= ST_REQ;
            irq_req_r <= 1'b1;
          end
        end
        ST_REQ: begin
          if (bus.irq_ack) begin
            state     <= ST_SERVICE;
            irq_req_r <= 1'b0;
          end else if (!(intcon_nxt[GIE_BIT] && pend_nxt)) begin
            state     <= ST_IDLE;
            irq_req_r <= 1'b0;
          end
        end
        ST_SERVICE: begin
          irq_req_r <= 1'b0;
          if (bus.retfie) state <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          irq_req_r <= 1'b0;
        end
      endcase
    end
  end

  // register outputs onto the bus
  always_comb begin
    bus.intcon_q = intcon_r;
    bus.pie1_q   = pie1_r;
    bus.irq_req  = irq_req_r;
    bus.wake     = pend;
  end

endmodule
